// File: rtl/con_ff_unit.sv
// con_ff_unit: condition flip-flop for branch decisions (clk, clr, bus_in, cond, con_in, con_clr, cap_a -> con_ff, con_valid, a_valid, cmp_err); compare codes 6-11 built under CON_FF_COMPARE_EN
module con_ff_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] bus_in,
  input  logic [3:0]       cond,
  input  logic             con_in,
  input  logic             con_clr,
  input  logic             cap_a,
  output logic             con_ff,
  output logic             con_valid,
  output logic             a_valid,
  output logic             cmp_err
);
  logic z, n, res, hit;
  assign z = bus_in == '0;
  assign n = bus_in[WIDTH-1];
`ifdef CON_FF_COMPARE_EN
  typedef enum logic {EMPTY, LOADED} state_t;
  state_t state;
  logic [WIDTH-1:0] a;
  logic is_cmp;
  assign is_cmp = cond >= 4'd6 && cond <= 4'd11;
  assign hit = res & !(is_cmp && state == EMPTY);
  assign a_valid = state == LOADED;
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      state   <= EMPTY;
      a       <= '0;
      cmp_err <= 1'b0;
    end else begin
      cmp_err <= con_in && is_cmp && state == EMPTY;
      if (cap_a) begin
        a     <= bus_in;
        state <= LOADED;
      end else if (con_in && is_cmp) begin
        state <= EMPTY;
      end
    end
`else
  logic unused_cap;
  assign unused_cap = cap_a;
  assign hit = res;
  assign a_valid = 1'b0;
  assign cmp_err = 1'b0;
`endif
  always_comb begin
    res = 1'b0;
    case (cond)
      4'd0:  res = z;
      4'd1:  res = !z;
      4'd2:  res = !n;
      4'd3:  res = n;
      4'd4:  res = !n && !z;
      4'd5:  res = n || z;
`ifdef CON_FF_COMPARE_EN
      4'd6:  res = bus_in == a;
      4'd7:  res = bus_in != a;
      4'd8:  res = $signed(bus_in) < $signed(a);
      4'd9:  res = $signed(bus_in) >= $signed(a);
      4'd10: res = bus_in < a;
      4'd11: res = bus_in >= a;
`endif
      4'd14: res = 1'b1;
      default: res = 1'b0;
    endcase
  end
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      con_ff    <= 1'b0;
      con_valid <= 1'b0;
    end else begin
      con_ff    <= con_clr ? 1'b0 : con_in ? hit : con_ff;
      con_valid <= con_in && !con_clr;
    end
endmodule

// File: tb/tb_con_ff_unit.sv
// tb_con_ff_unit: directed scoreboard bench for con_ff_unit
module tb_con_ff_unit;
  localparam int W = 32;
`ifdef CON_FF_COMPARE_EN
  localparam bit CE = 1'b1;
`else
  localparam bit CE = 1'b0;
`endif
  typedef struct packed {
    logic ff;
    logic v;
    logic av;
    logic err;
  } exp_t;
  logic clk = 1'b0;
  logic clr = 1'b0;
  logic [W-1:0] bus_in = '0;
  logic [3:0] cond = '0;
  logic con_in = 1'b0;
  logic con_clr = 1'b0;
  logic cap_a = 1'b0;
  logic con_ff, con_valid, a_valid, cmp_err;
  int vectors = 0;
  int miscompares = 0;
  exp_t q[$];
  con_ff_unit #(.WIDTH(W)) dut (
    .clk(clk), .clr(clr), .bus_in(bus_in), .cond(cond), .con_in(con_in),
    .con_clr(con_clr), .cap_a(cap_a), .con_ff(con_ff), .con_valid(con_valid),
    .a_valid(a_valid), .cmp_err(cmp_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".con_ff"}, con_ff, e.ff);
    chk({tag, ".con_valid"}, con_valid, e.v);
    chk({tag, ".a_valid"}, a_valid, e.av);
    chk({tag, ".cmp_err"}, cmp_err, e.err);
  endtask
  task automatic step(input string tag, input logic [W-1:0] b, input logic [3:0] c,
                      input logic ci, input logic cc, input logic ca,
                      input logic eff, input logic ev, input logic eav, input logic eerr);
    exp_t e;
    @(negedge clk);
    bus_in = b;
    cond = c;
    con_in = ci;
    con_clr = cc;
    cap_a = ca;
    e.ff = eff;
    e.v = ev;
    e.av = eav;
    e.err = eerr;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s scoreboard empty", tag);
    end else chk_all(tag, q.pop_front());
  endtask
  initial begin
    #1 clr = 1'b1;
    #2 chk_all("reset", '0);
    @(negedge clk);
    clr = 1'b0;
    step("z_hit",      32'h0,        4'd0,  1, 0, 0, 1, 1, 0, 0);
    step("hold",       32'h5,        4'd1,  0, 0, 0, 1, 0, 0, 0);
    step("z_miss",     32'h5,        4'd0,  1, 0, 0, 0, 1, 0, 0);
    step("n_set",      32'h80000000, 4'd3,  1, 0, 0, 1, 1, 0, 0);
    step("not_n",      32'h80000000, 4'd2,  1, 0, 0, 0, 1, 0, 0);
    step("n_or_z",     32'h80000000, 4'd5,  1, 0, 0, 1, 1, 0, 0);
    step("pos_zero",   32'h0,        4'd4,  1, 0, 0, 0, 1, 0, 0);
    step("pos",        32'h1,        4'd4,  1, 0, 0, 1, 1, 0, 0);
    step("nz_zero",    32'h0,        4'd1,  1, 0, 0, 0, 1, 0, 0);
    step("always1",    32'h0,        4'd14, 1, 0, 0, 1, 1, 0, 0);
    step("reserved",   32'h0,        4'd12, 1, 0, 0, 0, 1, 0, 0);
    step("always0",    32'h0,        4'd15, 1, 0, 0, 0, 1, 0, 0);
    step("cap1",       32'h1,        4'd0,  0, 0, 1, 0, 0, CE, 0);
    step("slt",        32'hFFFFFFFF, 4'd8,  1, 0, 0, CE, 1, 0, 0);
    step("recap1",     32'h1,        4'd0,  0, 0, 1, CE, 0, CE, 0);
    step("ult",        32'hFFFFFFFF, 4'd10, 1, 0, 0, 0, 1, 0, 0);
    step("cap_m1",     32'hFFFFFFFF, 4'd0,  0, 0, 1, 0, 0, CE, 0);
    step("sge",        32'h1,        4'd9,  1, 0, 0, CE, 1, 0, 0);
    step("cap10",      32'h10,       4'd0,  0, 0, 1, CE, 0, CE, 0);
    step("uge",        32'h10,       4'd11, 1, 0, 0, CE, 1, 0, 0);
    step("empty_eq",   32'h3,        4'd6,  1, 0, 0, 0, 1, 0, CE);
    step("err_gone",   32'h3,        4'd14, 1, 0, 0, 1, 1, 0, 0);
    step("eq_cap",     32'h7,        4'd6,  1, 0, 1, 0, 1, CE, CE);
    step("eq_a7",      32'h7,        4'd6,  1, 0, 0, CE, 1, 0, 0);
    step("cap9",       32'h9,        4'd0,  0, 0, 1, CE, 0, CE, 0);
    step("ne",         32'h2,        4'd7,  1, 0, 0, CE, 1, 0, 0);
    step("cap_noncmp", 32'h0,        4'd14, 1, 0, 1, 1, 1, CE, 0);
    step("clr_wins",   32'h0,        4'd14, 1, 1, 0, 0, 0, CE, 0);
    step("b2b_1",      32'h0,        4'd14, 1, 0, 0, 1, 1, CE, 0);
    step("b2b_2",      32'h5,        4'd0,  1, 0, 0, 0, 1, CE, 0);
    step("b2b_3",      32'h0,        4'd0,  1, 0, 0, 1, 1, CE, 0);
    #1 clr = 1'b1;
    #1 chk_all("async_clr", '0);
    @(negedge clk);
    clr = 1'b0;
    step("post_clr",   32'h0,        4'd0,  1, 0, 0, 1, 1, 0, 0);
    step("post_idle",  32'h0,        4'd15, 0, 0, 0, 1, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
